// File: rtl/arp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : arp_scheduler
// Description : Time-shares one voice (pitch lookup plus oscillator) between
//               four note requesters. One requester owns each step. A step
//               lasts max(step_period,1) clk cycles. The gate is high while
//               the in-step cycle counter is below gate_len.
//
//               Ports
//                 clk          : system clock, rising edge
//                 rst          : synchronous active-high reset
//                 req          : request line per requester
//                 deg_bus      : scale degree per requester, i at [i*DEG_W +: DEG_W]
//                 step_period  : step length in clk cycles (0 behaves as 1)
//                 gate_len     : gate-high length in clk cycles
//                 scale_degree : degree latched for the current step
//                 gate         : note gate
//                 step_strobe  : one-cycle pulse in the first cycle of a step
//                 active_idx   : requester served in the current step
//                 busy         : high while a step is in progress
//
//               Build option
//                 ARP_UPDOWN_EN : when defined, selection runs in ping-pong
//                                 order (0,1,2,3,2,1,0,1,...). When undefined,
//                                 selection is plain round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module arp_scheduler #(
    parameter int CNT_W = 20,
    parameter int DEG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*DEG_W-1:0]   deg_bus,
    input  logic [CNT_W-1:0]     step_period,
    input  logic [CNT_W-1:0]     gate_len,
    output logic [DEG_W-1:0]     scale_degree,
    output logic                 gate,
    output logic                 step_strobe,
    output logic [1:0]           active_idx,
    output logic                 busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_GATE_ON  = 2'd1;
    localparam logic [1:0]       c_GATE_OFF = 2'd2;
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] c_q,      c_d;
    logic             gate_q,   gate_d;
    logic             strobe_q, strobe_d;
    logic             busy_q,   busy_d;
    logic [DEG_W-1:0] deg_q,    deg_d;
    logic [1:0]       idx_q,    idx_d;
    // last_idx is kept apart from active_idx because the two reset to
    // different values: 0 on the output, 3 internally. With last_idx at 3,
    // the first round-robin scan begins at bit 0.
    logic [1:0]       last_q,   last_d;

`ifdef ARP_UPDOWN_EN
    logic             dir_up_q, dir_up_d;   // 1 = scanning upward
    logic             fresh_q,  fresh_d;    // no selection since reset
`endif

    // ------------------------------------------------------------------------
    // Requester selection
    // ------------------------------------------------------------------------
    logic [1:0] w_sel_idx;

`ifdef ARP_UPDOWN_EN
    logic [1:0] w_low_idx;
    logic       w_up_found;
    logic [1:0] w_up_idx;
    logic       w_dn_found;
    logic [1:0] w_dn_idx;
    logic       w_dir_nxt;

    always_comb begin : p_scan
        w_low_idx  = 2'd0;
        w_up_found = 1'b0;
        w_up_idx   = 2'd0;
        w_dn_found = 1'b0;
        w_dn_idx   = 2'd0;
        // A descending loop leaves the lowest qualifying index in place.
        for (int j = 3; j >= 0; j--) begin
            if (req[j]) begin
                w_low_idx = 2'(j);
            end
            if (req[j] && (2'(j) > last_q)) begin
                w_up_found = 1'b1;
                w_up_idx   = 2'(j);
            end
        end
        // An ascending loop leaves the highest index below last_idx.
        for (int j = 0; j <= 3; j++) begin
            if (req[j] && (2'(j) < last_q)) begin
                w_dn_found = 1'b1;
                w_dn_idx   = 2'(j);
            end
        end
    end

    always_comb begin : p_sel_pingpong
        w_sel_idx = last_q;
        w_dir_nxt = dir_up_q;
        if (fresh_q) begin
            // First pick after reset takes the lowest set bit.
            w_sel_idx = w_low_idx;
        end else if (dir_up_q) begin
            if (w_up_found) begin
                w_sel_idx = w_up_idx;
            end else if (w_dn_found) begin
                w_sel_idx = w_dn_idx;
                w_dir_nxt = 1'b0;
            end
        end else begin
            if (w_dn_found) begin
                w_sel_idx = w_dn_idx;
            end else if (w_up_found) begin
                w_sel_idx = w_up_idx;
                w_dir_nxt = 1'b1;
            end
        end
        // If neither direction finds a bit, last_idx is the only one set
        // and it is served again (the default above).
    end
`else
    always_comb begin : p_sel_rr
        w_sel_idx = last_q;
        // Candidates are last+1 .. last+4, where last+4 wraps to last itself.
        // A descending loop lets the nearest candidate win.
        for (int k = 4; k >= 1; k--) begin
            if (req[last_q + 2'(k)]) begin
                w_sel_idx = last_q + 2'(k);
            end
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Step timing
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] w_sp_eff;
    logic             w_step_end;
    logic [CNT_W:0]   w_c_inc;
    logic             w_any_req;
    logic             w_start;

    assign w_sp_eff  = (step_period == '0) ? c_ONE : step_period;
    // ">=" lets a step end promptly when step_period is cut mid-step below
    // the current count.
    assign w_step_end = (c_q >= (w_sp_eff - c_ONE));
    assign w_c_inc    = {1'b0, c_q} + {1'b0, c_ONE};
    assign w_any_req  = (req != 4'b0000);
    assign w_start    = w_any_req && ((state_q == c_IDLE) || w_step_end);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin : p_next
        state_d  = state_q;
        c_d      = c_q;
        gate_d   = gate_q;
        strobe_d = 1'b0;
        busy_d   = busy_q;
        deg_d    = deg_q;
        idx_d    = idx_q;
        last_d   = last_q;
`ifdef ARP_UPDOWN_EN
        dir_up_d = dir_up_q;
        fresh_d  = fresh_q;
`endif

        case (state_q)
            c_IDLE: begin
                c_d    = '0;
                gate_d = 1'b0;
                busy_d = 1'b0;
            end
            c_GATE_ON, c_GATE_OFF: begin
                if (w_step_end) begin
                    // A waiting request overrides this below with a new step.
                    state_d = c_IDLE;
                    c_d     = '0;
                    gate_d  = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    c_d     = w_c_inc[CNT_W-1:0];
                    // Gate is registered, so it is computed for the next count.
                    gate_d  = (w_c_inc < {1'b0, gate_len});
                    state_d = gate_d ? c_GATE_ON : c_GATE_OFF;
                end
            end
            default: begin
                state_d = c_IDLE;
                c_d     = '0;
                gate_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Start a step. This covers the first step after IDLE and also a
        // gap-free follow-on step at the end of the current one.
        if (w_start) begin
            state_d  = c_GATE_ON;
            c_d      = '0;
            gate_d   = (gate_len != '0);
            strobe_d = 1'b1;
            busy_d   = 1'b1;
            idx_d    = w_sel_idx;
            last_d   = w_sel_idx;
            deg_d    = deg_bus[int'(w_sel_idx)*DEG_W +: DEG_W];
`ifdef ARP_UPDOWN_EN
            dir_up_d = fresh_q ? 1'b1 : w_dir_nxt;
            fresh_d  = 1'b0;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin : p_regs
        if (rst) begin
            state_q  <= c_IDLE;
            c_q      <= '0;
            gate_q   <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            deg_q    <= '0;
            idx_q    <= 2'd0;
            last_q   <= 2'd3;
`ifdef ARP_UPDOWN_EN
            dir_up_q <= 1'b1;
            fresh_q  <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            gate_q   <= gate_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            deg_q    <= deg_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
`ifdef ARP_UPDOWN_EN
            dir_up_q <= dir_up_d;
            fresh_q  <= fresh_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign scale_degree = deg_q;
    assign gate         = gate_q;
    assign step_strobe  = strobe_q;
    assign active_idx   = idx_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_arp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_arp_scheduler
// Description : Self-checking bench for arp_scheduler. A table of scenarios
//               gives per-step expected index, degree, period and gate-high
//               count. Hand-written sequences cover request drop, reset
//               during a step, and idle behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arp_scheduler;

    localparam int CNT_W = 20;
    localparam int DEG_W = 4;

    logic              clk;
    logic              rst;
    logic [3:0]        req;
    logic [4*DEG_W-1:0] deg_bus;
    logic [CNT_W-1:0]  step_period;
    logic [CNT_W-1:0]  gate_len;
    logic [DEG_W-1:0]  scale_degree;
    logic              gate;
    logic              step_strobe;
    logic [1:0]        active_idx;
    logic              busy;

    int n_chk = 0;
    int n_err = 0;

    arp_scheduler #(.CNT_W(CNT_W), .DEG_W(DEG_W)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .deg_bus      (deg_bus),
        .step_period  (step_period),
        .gate_len     (gate_len),
        .scale_degree (scale_degree),
        .gate         (gate),
        .step_strobe  (step_strobe),
        .active_idx   (active_idx),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        req;
        logic [15:0]       deg;
        logic [CNT_W-1:0]  sp;
        logic [CNT_W-1:0]  gl;
        int                nsteps;
        int                period;
        int                gate_hi;
        int                idx  [8];
        int                degs [8];
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin : p_main
        int cnt;
        int ghi;

        rst = 1'b1; req = 4'b0000; deg_bus = '0;
        step_period = CNT_W'(8); gate_len = CNT_W'(3);

        // Scenario table
        tbl[0].req = 4'b0101; tbl[0].deg = 16'h0702; tbl[0].sp = CNT_W'(8); tbl[0].gl = CNT_W'(3);
        tbl[0].nsteps = 4; tbl[0].period = 8; tbl[0].gate_hi = 3;
        tbl[0].idx  = '{0, 2, 0, 2, 0, 0, 0, 0};
        tbl[0].degs = '{2, 7, 2, 7, 0, 0, 0, 0};

        tbl[1].req = 4'b1111; tbl[1].deg = 16'h7654; tbl[1].sp = CNT_W'(3); tbl[1].gl = CNT_W'(1);
        tbl[1].nsteps = 8; tbl[1].period = 3; tbl[1].gate_hi = 1;
`ifdef ARP_UPDOWN_EN
        tbl[1].idx  = '{0, 1, 2, 3, 2, 1, 0, 1};
        tbl[1].degs = '{4, 5, 6, 7, 6, 5, 4, 5};
`else
        tbl[1].idx  = '{0, 1, 2, 3, 0, 1, 2, 3};
        tbl[1].degs = '{4, 5, 6, 7, 4, 5, 6, 7};
`endif

        tbl[2].req = 4'b0011; tbl[2].deg = 16'h0019; tbl[2].sp = CNT_W'(8); tbl[2].gl = CNT_W'(10);
        tbl[2].nsteps = 4; tbl[2].period = 8; tbl[2].gate_hi = 8;
        tbl[2].idx  = '{0, 1, 0, 1, 0, 0, 0, 0};
        tbl[2].degs = '{9, 1, 9, 1, 0, 0, 0, 0};

        tbl[3].req = 4'b1000; tbl[3].deg = 16'hF000; tbl[3].sp = CNT_W'(0); tbl[3].gl = CNT_W'(0);
        tbl[3].nsteps = 5; tbl[3].period = 1; tbl[3].gate_hi = 0;
        tbl[3].idx  = '{3, 3, 3, 3, 3, 0, 0, 0};
        tbl[3].degs = '{15, 15, 15, 15, 15, 0, 0, 0};

        tbl[4].req = 4'b0100; tbl[4].deg = 16'h0A00; tbl[4].sp = CNT_W'(5); tbl[4].gl = CNT_W'(5);
        tbl[4].nsteps = 3; tbl[4].period = 5; tbl[4].gate_hi = 5;
        tbl[4].idx  = '{2, 2, 2, 0, 0, 0, 0, 0};
        tbl[4].degs = '{10, 10, 10, 0, 0, 0, 0, 0};

        // Reset state, sampled while rst is held
        repeat (2) @(negedge clk);
        chk("rst_strobe", int'(step_strobe), 0);
        chk("rst_gate",   int'(gate), 0);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_deg",    int'(scale_degree), 0);
        chk("rst_idx",    int'(active_idx), 0);
        rst = 1'b0;

        // Idle with no requests
        repeat (4) begin
            @(negedge clk);
            chk("idle_busy",   int'(busy), 0);
            chk("idle_gate",   int'(gate), 0);
            chk("idle_strobe", int'(step_strobe), 0);
        end

        // Table-driven scenarios
        for (int i = 0; i < 5; i++) begin
            do_reset();
            deg_bus     = tbl[i].deg;
            step_period = tbl[i].sp;
            gate_len    = tbl[i].gl;
            @(negedge clk);
            chk($sformatf("s%0d_pre_busy", i), int'(busy), 0);
            req = tbl[i].req;
            @(negedge clk);
            chk($sformatf("s%0d_first_strobe", i), int'(step_strobe), 1);
            for (int s = 0; s < tbl[i].nsteps; s++) begin
                chk($sformatf("s%0d_step%0d_idx", i, s), int'(active_idx), tbl[i].idx[s]);
                chk($sformatf("s%0d_step%0d_deg", i, s), int'(scale_degree), tbl[i].degs[s]);
                cnt = 0;
                ghi = 0;
                do begin
                    if (gate) ghi++;
                    if (!busy) cnt = 100;
                    cnt++;
                    @(negedge clk);
                end while (!step_strobe && cnt < 64);
                chk($sformatf("s%0d_step%0d_period", i, s), cnt, tbl[i].period);
                chk($sformatf("s%0d_step%0d_gate_hi", i, s), ghi, tbl[i].gate_hi);
            end
        end

        // Request dropped at c=2: the step finishes, then the FSM returns to IDLE
        do_reset();
        deg_bus = 16'h0003; step_period = CNT_W'(8); gate_len = CNT_W'(3);
        req = 4'b0001;
        @(negedge clk);
        chk("drop_strobe", int'(step_strobe), 1);
        repeat (2) @(negedge clk);
        req = 4'b0000;
        repeat (5) @(negedge clk);
        chk("drop_c7_busy",   int'(busy), 1);
        chk("drop_c7_strobe", int'(step_strobe), 0);
        chk("drop_c7_deg",    int'(scale_degree), 3);
        @(negedge clk);
        chk("drop_end_busy",   int'(busy), 0);
        chk("drop_end_gate",   int'(gate), 0);
        chk("drop_end_strobe", int'(step_strobe), 0);
        repeat (3) @(negedge clk);
        chk("drop_idle_busy",   int'(busy), 0);
        chk("drop_idle_strobe", int'(step_strobe), 0);

        // Reset pulsed at c=4 of a GATE_ON step
        do_reset();
        deg_bus = 16'h0650; step_period = CNT_W'(8); gate_len = CNT_W'(6);
        req = 4'b0110;
        @(negedge clk);
        chk("mrst_first_idx", int'(active_idx), 1);
        repeat (4) @(negedge clk);
        chk("mrst_c4_gate", int'(gate), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_strobe", int'(step_strobe), 0);
        chk("mrst_gate",   int'(gate), 0);
        chk("mrst_busy",   int'(busy), 0);
        chk("mrst_deg",    int'(scale_degree), 0);
        chk("mrst_idx",    int'(active_idx), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_new_strobe", int'(step_strobe), 1);
        chk("mrst_new_idx",    int'(active_idx), 1);
        chk("mrst_new_deg",    int'(scale_degree), 5);
        chk("mrst_new_gate",   int'(gate), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
